// File: rtl/instr_trace_uart_tx.sv
// Snapshots CPU state on each retired instruction and streams it as an 8N1 UART frame.
// Optional TRACE_CHECKSUM_EN appends an XOR checksum byte over the bytes following the sync byte.
module instr_trace_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  instr_complete_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  input  logic                  flag_zero_i,
  input  logic                  flag_negative_i,
  input  logic                  flag_carry_i,
  output logic                  uart_tx_o,
  output logic                  busy_o,
  output logic [7:0]            drop_count_o
);

  localparam int SNAP_W = ADDR_WIDTH + 4 * DATA_WIDTH;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef TRACE_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  // Snapshot packing: {pc_hi, pc_lo, A, B, C, flags}, one byte per frame slot after the sync byte.
  function automatic logic [7:0] frame_byte(input logic [SNAP_W-1:0] s, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0: b = 8'hA5;
      3'd1: b = s[47:40];
      3'd2: b = s[39:32];
      3'd3: b = s[31:24];
      3'd4: b = s[23:16];
      3'd5: b = s[15:8];
      3'd6: b = s[7:0];
`ifdef TRACE_CHECKSUM_EN
      3'd7: b = s[47:40] ^ s[39:32] ^ s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
`endif
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [2:0]          idx_q, idx_d;
  logic [SNAP_W-1:0]   frame_q, frame_d;
  logic                pend_vld_q, pend_vld_d;
  logic [SNAP_W-1:0]   pend_q, pend_d;
  logic [7:0]          drop_q, drop_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                bit_end;
  logic                capture;
  logic                consume;
  logic [7:0]          cur_byte;

  assign bit_end = (baud_q == BAUD_LAST);
  assign capture = instr_complete_i && enable_i;
  assign consume = (state_q == S_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    pend_q  <= pend_d;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: if (pend_vld_q) state_d = S_LOAD;
      S_LOAD: begin
        frame_d = pend_q;
        idx_d   = '0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = pend_vld_q ? S_LOAD : S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full slot only accepts a new snapshot in the cycle it is being moved into the frame register.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    if (consume) pend_vld_d = 1'b0;
    if (capture) begin
      if (pend_vld_q && !consume) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = {pc_i, a_i, b_i, c_i, 5'b0, flag_negative_i, flag_zero_i, flag_carry_i};
      end
    end
  end

  // Outputs are registered from next-state values so the line changes in step with the FSM.
  always_comb begin
    cur_byte = frame_byte(frame_d, idx_d);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || pend_vld_d;
  end

  assign uart_tx_o    = tx_q;
  assign busy_o       = busy_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_instr_trace_uart_tx.sv
// Directed bench for instr_trace_uart_tx with CLKS_PER_BIT=4; a UART monitor decodes uart_tx_o.
module tb_instr_trace_uart_tx;

  localparam int CPB = 4;
`ifdef TRACE_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_i = 1'b1;
  logic        instr_complete_i = 1'b0;
  logic [15:0] pc_i = '0;
  logic [7:0]  a_i = '0, b_i = '0, c_i = '0;
  logic        flag_zero_i = 1'b0, flag_negative_i = 1'b0, flag_carry_i = 1'b0;
  logic        uart_tx_o, busy_o;
  logic [7:0]  drop_count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_t, frame_first, f1_last, f2_first;
  logic saw_low, saw_busy;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_s[$];
  logic [7:0] mon_b;
  int         mon_t;

  instr_trace_uart_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .instr_complete_i(instr_complete_i),
    .pc_i(pc_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .flag_zero_i(flag_zero_i), .flag_negative_i(flag_negative_i), .flag_carry_i(flag_carry_i),
    .uart_tx_o(uart_tx_o), .busy_o(busy_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: start detected on a low sample, then each bit sampled mid-period.
  always begin
    @(negedge clk);
    if (uart_tx_o === 1'b0) begin
      mon_t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        mon_b[k] = uart_tx_o;
      end
      repeat (CPB) @(negedge clk);
      rx_s.push_back(uart_tx_o);
      rx_q.push_back(mon_b);
      rx_t.push_back(mon_t);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] pc, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic n, input logic z, input logic cf);
    @(negedge clk);
    pc_i = pc; a_i = a; b_i = b; c_i = c;
    flag_negative_i = n; flag_zero_i = z; flag_carry_i = cf;
    instr_complete_i = 1'b1;
    @(negedge clk);
    instr_complete_i = 1'b0;
  endtask

  task automatic get_byte(input string tag, input logic [7:0] exp);
    int w = 0;
    while (rx_q.size() == 0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " arrived"}, 32'(rx_q.size() > 0), 32'd1);
    if (rx_q.size() > 0) begin
      chk(tag, 32'(rx_q[0]), 32'(exp));
      chk({tag, " stop"}, 32'(rx_s[0]), 32'd1);
      last_t = rx_t[0];
      void'(rx_q.pop_front());
      void'(rx_s.pop_front());
      void'(rx_t.pop_front());
    end
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] pc, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic [7:0] f,
                              input logic [7:0] ck);
    logic [7:0] e [8];
    e[0] = 8'hA5; e[1] = pc[15:8]; e[2] = pc[7:0];
    e[3] = a; e[4] = b; e[5] = c; e[6] = f; e[7] = ck;
    for (int i = 0; i < NB; i++) begin
      get_byte($sformatf("%s b%0d", tag, i), e[i]);
      if (i == 0) frame_first = last_t;
    end
    chk({tag, " span"}, 32'(last_t - frame_first), 32'((NB - 1) * 10 * CPB));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst tx", 32'(uart_tx_o), 32'd1);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst drop", 32'(drop_count_o), 32'd0);

    // Single frame with start-bit latency
    pulse(16'h0012, 8'h01, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    chk("A busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("A load tx", 32'(uart_tx_o), 32'd1);
    @(negedge clk);
    chk("A start tx", 32'(uart_tx_o), 32'd0);
    expect_frame("A", 16'h0012, 8'h01, 8'h00, 8'h03, 8'h04, 8'h14);
    repeat (5) @(negedge clk);
    chk("A idle busy", 32'(busy_o), 32'd0);

    // Two pulses 10 cycles apart: back-to-back frames separated by one LOAD cycle
    pulse(16'h1234, 8'hAA, 8'h55, 8'h0F, 1'b0, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    pulse(16'hABCD, 8'h80, 8'h01, 8'hFE, 1'b1, 1'b1, 1'b1);
    expect_frame("F1", 16'h1234, 8'hAA, 8'h55, 8'h0F, 8'h03, 8'hD5);
    f1_last = last_t;
    expect_frame("F2", 16'hABCD, 8'h80, 8'h01, 8'hFE, 8'h07, 8'h1E);
    f2_first = frame_first;
    chk("F gap", 32'(f2_first - f1_last), 32'(10 * CPB + 1));

    // Three pulses during one frame: third is dropped
    repeat (10) @(negedge clk);
    pulse(16'h0001, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    pulse(16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    chk("drop0", 32'(drop_count_o), 32'd0);
    repeat (5) @(negedge clk);
    pulse(16'h5555, 8'h66, 8'h77, 8'h88, 1'b1, 1'b1, 1'b1);
    chk("drop1", 32'(drop_count_o), 32'd1);
    expect_frame("P", 16'h0001, 8'h11, 8'h22, 8'h33, 8'h00, 8'h01);
    expect_frame("Q", 16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'hFD);
    repeat (100) @(negedge clk);
    chk("R absent", 32'(rx_q.size()), 32'd0);
    chk("R busy", 32'(busy_o), 32'd0);
    chk("R drop", 32'(drop_count_o), 32'd1);

    // Disabled capture
    enable_i = 1'b0;
    pulse(16'h7777, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    saw_low = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx_o !== 1'b1) saw_low = 1'b1;
      if (busy_o !== 1'b0) saw_busy = 1'b1;
      @(negedge clk);
    end
    chk("dis start", 32'(saw_low), 32'd0);
    chk("dis busy", 32'(saw_busy), 32'd0);
    chk("dis rx", 32'(rx_q.size()), 32'd0);
    enable_i = 1'b1;

    // Reset during byte 3 of a frame
    pulse(16'h0012, 8'h01, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    repeat (2 + 3 * 10 * CPB + 10) @(negedge clk);
    chk("mid busy pre", 32'(busy_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid rst tx", 32'(uart_tx_o), 32'd1);
    chk("mid rst busy", 32'(busy_o), 32'd0);
    chk("mid rst drop", 32'(drop_count_o), 32'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    rx_q.delete();
    rx_s.delete();
    rx_t.delete();

    // Recovery frame; with the checksum option its last byte is 8'h04
    pulse(16'h0000, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1);
    expect_frame("K", 16'h0000, 8'h01, 8'h01, 8'h01, 8'h05, 8'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
